mem_port_arbiter: RTL

//   Shares one single-port memory between the CPU instruction-fetch port and data port.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 39 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Which CPU port owns the current access
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Latency counter width; covers MEM_LAT 0..15
  localparam int LAT_W = 4;

  // Map a one-hot grant vector (bit 0 = fetch, bit 1 = data) onto an owner
  function automatic owner_t owner_of(input logic [1:0] gnt);
    return gnt[1] ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side handshakes plus memory-side bus of the shared memory port.
// 'slave' is the arbiter's view, 'master' is the CPU core plus memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time
// is granted. The memory of the last winner only moves when a grant is issued.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  owner_t r_last_gnt;

  // Grant selection: single requester wins, tie goes to the port not last granted
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (r_last_gnt == OWN_DM) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end else begin
      o_gnt = 2'b00;
    end
  end

  // Remember the most recent winner; reset makes the fetch port win the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_gnt <= OWN_DM;
    end else if (o_gnt != 2'b00) begin
      r_last_gnt <= owner_of(o_gnt);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the CPU fetch and data
// ports. One access at a time: grant (IDLE) -> MEM_LAT+1 cycles of ACCESS ->
// one RESP cycle carrying the owner's rvalid pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic              r_we;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_acc_last;

  // Arbitration only happens in IDLE and never while reset is asserted,
  // so both readies are held low during reset.
  assign w_arb_en   = (r_state == IDLE) && rst;
  assign w_acc_last = (r_cnt == LAT_W'(MEM_LAT));

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_arb_en),
    .i_req ({bus.dm_req, bus.if_req}),
    .o_gnt (w_gnt)
  );

  assign bus.if_ready  = w_gnt[0];
  assign bus.dm_ready  = w_gnt[1];
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign busy          = (r_state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt != 2'b00) begin
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (w_acc_last) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = ACCESS;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch at grant, latency count, read-data capture and rvalid pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_owner    <= owner_of(w_gnt);
            r_we       <= w_gnt[1] & bus.dm_we;
            r_cnt      <= '0;
            r_mem_en   <= 1'b1;
            r_mem_we   <= w_gnt[1] & bus.dm_we;
            r_mem_addr <= w_gnt[1] ? bus.dm_addr : bus.if_addr;
            if (w_gnt[1]) begin
              r_mem_wdata <= bus.dm_wdata;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + LAT_W'(1);
          if (w_acc_last) begin
            if (r_owner == OWN_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end else begin
              r_dm_rvalid <= 1'b1;
              if (!r_we) begin
                r_dm_rdata <= bus.mem_rdata;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
